execute_stage_mx: RTL

Parametrised execute stage for the pipelined OTTER core, sitting between the ID/EX register and the memory stage. It runs single-cycle RV32I ALU operations and adds an iterative multi-cycle unsigned multiplier (MUL / MULHU). It owns a single-edge EX/MEM pipeline register with valid, stall and flush support, and raises a busy signal so that fetch and decode hold while a multiply is in flight.

---
 rtl/execute_stage_mx.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/execute_stage_mx.sv
// OTTER execute stage: single-cycle RV32I ALU, iterative radix-2 unsigned multiplier
// (MUL / MULHU), and the EX/MEM pipeline register with valid, stall and flush handling.
module execute_stage_mx #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RD_W = 5
) (
  input  logic            EXECUTE_CLOCK,
  input  logic            EXECUTE_RESET,
  input  logic            ID_EX_VALID,
  input  logic [XLEN-1:0] ID_EX_ALU_A,
  input  logic [XLEN-1:0] ID_EX_ALU_B,
  input  logic [3:0]      ID_EX_ALU_FUN,
  input  logic            ID_EX_MUL,
  input  logic            ID_EX_MULH,
  input  logic [XLEN-1:0] ID_EX_RS2,
  input  logic [XLEN-1:0] ID_EX_PC_4,
  input  logic [RD_W-1:0] ID_EX_RD,
  input  logic            ID_EX_REG_WRITE,
  input  logic            ID_EX_MEM_WRITE,
  input  logic            ID_EX_MEM_READ2,
  input  logic [1:0]      ID_EX_RF_WR_SEL,
  input  logic            EX_FLUSH,
  input  logic            MEM_STALL,
  output logic            EX_BUSY,
  output logic            EX_MS_VALID,
  output logic            EX_MS_REG_WRITE,
  output logic            EX_MS_MEM_WRITE,
  output logic            EX_MS_MEM_READ2,
  output logic [XLEN-1:0] EX_MS_ALU_RESULT,
  output logic [XLEN-1:0] EX_MS_RS2,
  output logic [XLEN-1:0] EX_MS_PC_4,
  output logic [1:0]      EX_MS_RF_WR_SEL,
  output logic [RD_W-1:0] EX_MS_RD
);

  localparam int unsigned SH_W = $clog2(XLEN);
  localparam int unsigned ACC_W = 2 * XLEN;

  typedef enum logic [1:0] {IDLE, MUL_RUN, MUL_DONE} state_t;

  state_t             state;
  logic [SH_W-1:0]    cnt;
  logic [ACC_W-1:0]   acc;
  logic [XLEN-1:0]    mul_a;
  logic [XLEN-1:0]    mul_b;
  logic               mul_hi;
  logic [XLEN-1:0]    lat_rs2;
  logic [XLEN-1:0]    lat_pc_4;
  logic [RD_W-1:0]    lat_rd;
  logic               lat_reg_write;
  logic               lat_mem_write;
  logic               lat_mem_read2;
  logic [1:0]         lat_rf_wr_sel;

  logic [SH_W-1:0]    shamt;
  logic [XLEN-1:0]    alu_result;
  logic [XLEN:0]      step_sum;
  logic [ACC_W-1:0]   acc_step;
  logic [ACC_W-1:0]   prod_src;
  logic [XLEN-1:0]    product;
  logic               issue;
  logic               last_step;
  logic               product_ready;

  logic               nx_valid;
  logic               nx_reg_write;
  logic               nx_mem_write;
  logic               nx_mem_read2;
  logic [XLEN-1:0]    nx_result;
  logic [XLEN-1:0]    nx_rs2;
  logic [XLEN-1:0]    nx_pc_4;
  logic [1:0]         nx_rf_wr_sel;
  logic [RD_W-1:0]    nx_rd;

  assign shamt = ID_EX_ALU_B[SH_W-1:0];

  // Single-cycle ALU; unused function codes yield zero
  always_comb begin
    alu_result = '0;
    case (ID_EX_ALU_FUN)
      4'b0000: alu_result = ID_EX_ALU_A + ID_EX_ALU_B;
      4'b1000: alu_result = ID_EX_ALU_A - ID_EX_ALU_B;
      4'b0001: alu_result = ID_EX_ALU_A << shamt;
      4'b0010: alu_result = {{(XLEN-1){1'b0}}, ($signed(ID_EX_ALU_A) < $signed(ID_EX_ALU_B))};
      4'b0011: alu_result = {{(XLEN-1){1'b0}}, (ID_EX_ALU_A < ID_EX_ALU_B)};
      4'b0100: alu_result = ID_EX_ALU_A ^ ID_EX_ALU_B;
      4'b0101: alu_result = ID_EX_ALU_A >> shamt;
      4'b1101: alu_result = XLEN'($signed(ID_EX_ALU_A) >>> shamt);
      4'b0110: alu_result = ID_EX_ALU_A | ID_EX_ALU_B;
      4'b0111: alu_result = ID_EX_ALU_A & ID_EX_ALU_B;
      4'b1001: alu_result = ID_EX_ALU_A;
      default: alu_result = '0;
    endcase
  end

  // One shift-add step: add A into the upper half when the current multiplier bit is set, then shift right
  always_comb begin
    step_sum = {1'b0, acc[ACC_W-1:XLEN]} + {1'b0, (mul_b[0] ? mul_a : {XLEN{1'b0}})};
    acc_step = {step_sum, acc[XLEN-1:1]};
    prod_src = (state == MUL_DONE) ? acc : acc_step;
    product  = mul_hi ? prod_src[ACC_W-1:XLEN] : prod_src[XLEN-1:0];
  end

  assign issue         = (state == IDLE) && ID_EX_VALID && ID_EX_MUL && !EX_FLUSH;
  assign last_step     = (state == MUL_RUN) && (cnt == SH_W'(XLEN - 1));
  assign product_ready = !EX_FLUSH && (last_step || (state == MUL_DONE));
  assign EX_BUSY       = MEM_STALL || issue || ((state == MUL_RUN) && !last_step && !EX_FLUSH);

  // Next EX/MEM payload; anything other than a plain ALU op or a finished product is a bubble
  always_comb begin
    nx_valid     = 1'b0;
    nx_reg_write = 1'b0;
    nx_mem_write = 1'b0;
    nx_mem_read2 = 1'b0;
    nx_result    = alu_result;
    nx_rs2       = ID_EX_RS2;
    nx_pc_4      = ID_EX_PC_4;
    nx_rd        = ID_EX_RD;
    nx_rf_wr_sel = ID_EX_RF_WR_SEL;
    if ((state == IDLE) && !issue) begin
      nx_valid     = ID_EX_VALID && !EX_FLUSH;
      nx_reg_write = ID_EX_REG_WRITE && nx_valid;
      nx_mem_write = ID_EX_MEM_WRITE && nx_valid;
      nx_mem_read2 = ID_EX_MEM_READ2 && nx_valid;
    end else if (product_ready) begin
      nx_valid     = 1'b1;
      nx_reg_write = lat_reg_write;
      nx_mem_write = lat_mem_write;
      nx_mem_read2 = lat_mem_read2;
      nx_result    = product;
      nx_rs2       = lat_rs2;
      nx_pc_4      = lat_pc_4;
      nx_rd        = lat_rd;
      nx_rf_wr_sel = lat_rf_wr_sel;
    end
  end

  // Multiplier control FSM and operand/control latches
  always_ff @(posedge EXECUTE_CLOCK or posedge EXECUTE_RESET) begin
    if (EXECUTE_RESET) begin
      state         <= IDLE;
      cnt           <= '0;
      acc           <= '0;
      mul_a         <= '0;
      mul_b         <= '0;
      mul_hi        <= 1'b0;
      lat_rs2       <= '0;
      lat_pc_4      <= '0;
      lat_rd        <= '0;
      lat_reg_write <= 1'b0;
      lat_mem_write <= 1'b0;
      lat_mem_read2 <= 1'b0;
      lat_rf_wr_sel <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            mul_a         <= ID_EX_ALU_A;
            mul_b         <= ID_EX_ALU_B;
            mul_hi        <= ID_EX_MULH;
            lat_rs2       <= ID_EX_RS2;
            lat_pc_4      <= ID_EX_PC_4;
            lat_rd        <= ID_EX_RD;
            lat_reg_write <= ID_EX_REG_WRITE;
            lat_mem_write <= ID_EX_MEM_WRITE;
            lat_mem_read2 <= ID_EX_MEM_READ2;
            lat_rf_wr_sel <= ID_EX_RF_WR_SEL;
            acc           <= '0;
            cnt           <= '0;
            state         <= MUL_RUN;
          end
        end
        MUL_RUN: begin
          if (EX_FLUSH) begin
            state <= IDLE;
          end else begin
            acc   <= acc_step;
            mul_b <= mul_b >> 1;
            cnt   <= cnt + SH_W'(1);
            if (last_step) state <= MEM_STALL ? MUL_DONE : IDLE;
          end
        end
        MUL_DONE: begin
          if (EX_FLUSH || !MEM_STALL) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // EX/MEM pipeline register; a memory stall freezes every field
  always_ff @(posedge EXECUTE_CLOCK or posedge EXECUTE_RESET) begin
    if (EXECUTE_RESET) begin
      EX_MS_VALID      <= 1'b0;
      EX_MS_REG_WRITE  <= 1'b0;
      EX_MS_MEM_WRITE  <= 1'b0;
      EX_MS_MEM_READ2  <= 1'b0;
      EX_MS_ALU_RESULT <= '0;
      EX_MS_RS2        <= '0;
      EX_MS_PC_4       <= '0;
      EX_MS_RF_WR_SEL  <= '0;
      EX_MS_RD         <= '0;
    end else if (!MEM_STALL) begin
      EX_MS_VALID      <= nx_valid;
      EX_MS_REG_WRITE  <= nx_reg_write;
      EX_MS_MEM_WRITE  <= nx_mem_write;
      EX_MS_MEM_READ2  <= nx_mem_read2;
      EX_MS_ALU_RESULT <= nx_result;
      EX_MS_RS2        <= nx_rs2;
      EX_MS_PC_4       <= nx_pc_4;
      EX_MS_RF_WR_SEL  <= nx_rf_wr_sel;
      EX_MS_RD         <= nx_rd;
    end
  end

endmodule
